// File: rtl/mul_div_unit.sv
// ============================================================================
// Module   : mul_div_unit
// Brief    : Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO
// Revision : 1.0
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic                  hi_wen,
    input  logic                  lo_wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_is_div;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_div0;
    logic [W-1:0]      r_a_raw;
    logic [W-1:0]      r_opa;
    logic [2*W-1:0]    r_acc;
    logic [W-1:0]      r_rem;
    logic              r_busy;
    logic              r_done;
    logic [W-1:0]      r_hi;
    logic [W-1:0]      r_lo;

    logic              w_signed;
    logic [W-1:0]      w_abs_a;
    logic [W-1:0]      w_abs_b;
    logic [W:0]        w_mul_sum;
    logic [2*W-1:0]    w_mul_next;
    logic [W:0]        w_div_shift;
    logic [W:0]        w_div_diff;
    logic              w_div_ok;
    logic [2*W-1:0]    w_prod_fix;
    logic [W-1:0]      w_quo_fix;
    logic [W-1:0]      w_rem_fix;

    assign w_signed = ~op[0];
    assign w_abs_a  = (w_signed && src_a[W-1]) ? -src_a : src_a;
    assign w_abs_b  = (w_signed && src_b[W-1]) ? -src_b : src_b;

    // Multiply: r_acc holds {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_acc[0] ? r_opa : {W{1'b0}})};
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // Divide: r_acc[W-1:0] shifts dividend bits out and quotient bits in.
    // The remainder stays below the divisor, so W stored bits suffice;
    // the shifted trial value needs W+1.
    assign w_div_shift = {r_rem, r_acc[W-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opa};
    assign w_div_ok    = ~w_div_diff[W];

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_a_raw  <= '0;
            r_opa    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (hi_wen) r_hi <= wdata;
                    if (lo_wen) r_lo <= wdata;
                    if (start) begin
                        r_state  <= S_CALC;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_is_div <= op[1];
                        r_a_raw  <= src_a;
                        r_div0   <= (src_b == '0);
                        r_neg_q  <= w_signed & (src_a[W-1] ^ src_b[W-1]);
                        r_neg_r  <= w_signed & src_a[W-1];
                        r_rem    <= '0;
                        if (op[1]) begin
                            r_opa <= w_abs_b;
                            r_acc <= {{W{1'b0}}, w_abs_a};
                        end else begin
                            r_opa <= w_abs_a;
                            r_acc <= {{W{1'b0}}, w_abs_b};
                        end
                    end
                end
                S_CALC: begin
                    if (r_is_div) begin
                        r_acc <= {r_acc[2*W-1:W], r_acc[W-2:0], w_div_ok};
                        r_rem <= w_div_ok ? w_div_diff[W-1:0] : w_div_shift[W-1:0];
                    end else begin
                        r_acc <= w_mul_next;
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) r_state <= S_SIGN;
                end
                S_SIGN: begin
                    if (!r_is_div) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end else if (r_div0) begin
                        r_lo <= '1;
                        r_hi <= r_a_raw;
                    end else begin
                        r_lo <= w_quo_fix;
                        r_hi <= w_rem_fix;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module   : tb_mul_div_unit
// Brief    : Scoreboard bench for mul_div_unit against a 64-bit arithmetic model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

    localparam int W = 32;

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic          start  = 1'b0;
    logic [1:0]    op     = 2'b00;
    logic [W-1:0]  src_a  = '0;
    logic [W-1:0]  src_b  = '0;
    logic          hi_wen = 1'b0;
    logic          lo_wen = 1'b0;
    logic [W-1:0]  wdata  = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    mul_div_unit #(.DATA_WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .hi_wen (hi_wen),
        .lo_wen (lo_wen),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t scb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; {hi,lo}
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        longint      sa;
        longint      sbv;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (o)
            2'b00:   r = 64'(sa * sbv);
            2'b01:   r = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 32'd0)      r = {a, 32'hFFFF_FFFF};
                else if (o == 2'b10) r = {32'(sa % sbv), 32'(sa / sbv)};
                else                 r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] special [5];
        special[0] = 32'h0000_0000;
        special[1] = 32'h0000_0001;
        special[2] = 32'hFFFF_FFFF;
        special[3] = 32'h8000_0000;
        special[4] = 32'h7FFF_FFFF;
        case ($urandom_range(3))
            0:       return special[$urandom_range(4)];
            1:       return 32'($urandom_range(300));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (prev_done) chk("done_single_cycle", 64'(done), 64'd0);
            if (done) begin
                if (scb.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    mon_e = scb.pop_front();
                    chk("result_hi_lo", {hi, lo}, {mon_e.hi, mon_e.lo});
                    chk("latency_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("busy_low_at_done", 64'(busy), 64'd0);
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy) begin
            @(negedge clk);
            guard++;
            if (guard > 100) begin
                errors++;
                $display("FAIL busy_timeout: busy got 1 expected 0");
                $fatal(1, "busy never cleared");
            end
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit mt);
        exp_t        e;
        logic [63:0] r;
        wait_idle();
        start  = 1'b1;
        op     = o;
        src_a  = a;
        src_b  = b;
        hi_wen = mt;
        wdata  = 32'hCAFE_0001;
        r      = model(o, a, b);
        e.hi   = r[63:32];
        e.lo   = r[31:0];
        e.cyc  = cyc + 34;
        scb.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        hi_wen = 1'b0;
        src_a  = $urandom;
        src_b  = $urandom;
        chk("busy_after_start", 64'(busy), 64'd1);
        if (mt) chk("mthi_with_start", 64'(hi), 64'h0000_0000_CAFE_0001);
    endtask

    logic [31:0] h0;
    logic [31:0] l0;
    int          guard;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_hi_lo", {hi, lo}, 64'd0);
        chk("reset_busy_done", 64'({busy, done}), 64'd0);
        rst = 1'b1;

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
        issue(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        issue(2'b11, 32'd100, 32'd7, 1'b0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(2'b11, 32'h0000_1234, 32'd0, 1'b0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b1);

        // Start and MTHI while busy must both be dropped
        issue(2'b01, 32'd3, 32'd4, 1'b0);
        h0 = hi;
        l0 = lo;
        repeat (5) @(negedge clk);
        start  = 1'b1;
        op     = 2'b10;
        src_a  = 32'd9;
        src_b  = 32'd3;
        hi_wen = 1'b1;
        wdata  = 32'h0000_AAAA;
        @(negedge clk);
        start  = 1'b0;
        hi_wen = 1'b0;
        chk("hold_hi_lo_while_busy", {hi, lo}, {h0, l0});
        chk("still_busy", 64'(busy), 64'd1);
        wait_idle();
        lo_wen = 1'b1;
        wdata  = 32'h0000_0055;
        @(negedge clk);
        lo_wen = 1'b0;
        chk("mtlo_write", 64'(lo), 64'h55);
        chk("mtlo_hi_kept", 64'(hi), 64'd0);

        // Asynchronous reset in the middle of CALC
        issue(2'b01, 32'd7, 32'd9, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midop_reset_busy_done", 64'({busy, done}), 64'd0);
        chk("midop_reset_hi_lo", {hi, lo}, 64'd0);
        scb.delete();
        @(negedge clk);
        rst = 1'b1;
        issue(2'b01, 32'd2, 32'd3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(3)), pick(), pick(), 1'b0);
        end

        guard = 0;
        while (scb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("scoreboard_drained", 64'(scb.size()), 64'd0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
